// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between an instruction-fetch requester
// and a load/store requester, with at most one transaction outstanding.
// Grants are combinational in IDLE; the selected request is registered and
// presented on the memory port in ISSUE, and the response is routed back to
// its owner in WAIT.
// Optional macro ARB_ROUND_ROBIN_EN: when defined, the requester not served
// last wins a tie. When undefined, the data port always wins a tie.
module mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  // instruction fetch port
  input  logic                if_req_i,
  input  logic [ADDR_W-1:0]   if_addr_i,
  output logic                if_gnt_o,
  output logic                if_rvalid_o,
  output logic [DATA_W-1:0]   if_rdata_o,
  // load/store port
  input  logic                d_req_i,
  input  logic                d_we_i,
  input  logic [DATA_W/8-1:0] d_be_i,
  input  logic [ADDR_W-1:0]   d_addr_i,
  input  logic [DATA_W-1:0]   d_wdata_i,
  output logic                d_gnt_o,
  output logic                d_rvalid_o,
  output logic [DATA_W-1:0]   d_rdata_o,
  // shared memory port
  output logic                mem_req_o,
  output logic                mem_we_o,
  output logic [DATA_W/8-1:0] mem_be_o,
  output logic [ADDR_W-1:0]   mem_addr_o,
  output logic [DATA_W-1:0]   mem_wdata_o,
  input  logic                mem_gnt_i,
  input  logic                mem_rvalid_i,
  input  logic [DATA_W-1:0]   mem_rdata_i,
  // status
  output logic                busy_o
);

  localparam int BE_W = DATA_W / 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  state_t              r_state;
  logic                r_owner_d;   // 1 = load/store owns the transaction
  logic                r_we;
  logic [BE_W-1:0]     r_be;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
`ifdef ARB_ROUND_ROBIN_EN
  logic                r_last_d;    // 1 = load/store was served most recently
`endif

  logic w_idle;
  logic w_any_req;
  logic w_pick_d;
  logic w_resp;

  assign w_idle    = (r_state == IDLE);
  assign w_any_req = if_req_i | d_req_i;

  // Tie-break policy: only matters when both requesters are active.
`ifdef ARB_ROUND_ROBIN_EN
  assign w_pick_d = d_req_i & (~if_req_i | ~r_last_d);
`else
  assign w_pick_d = d_req_i;
`endif

  // Grants are gated by reset so every output is 0 while rst_ni is low.
  assign d_gnt_o  = rst_ni & w_idle & w_pick_d;
  assign if_gnt_o = rst_ni & w_idle & if_req_i & ~w_pick_d;

  // A response is only accepted in WAIT; stray mem_rvalid_i elsewhere is dropped.
  assign w_resp      = (r_state == WAIT) & mem_rvalid_i;
  assign if_rvalid_o = w_resp & ~r_owner_d;
  assign d_rvalid_o  = w_resp & r_owner_d;
  assign if_rdata_o  = if_rvalid_o ? mem_rdata_i : '0;
  assign d_rdata_o   = d_rvalid_o  ? mem_rdata_i : '0;

  assign mem_req_o   = (r_state == ISSUE);
  assign mem_we_o    = r_we;
  assign mem_be_o    = r_be;
  assign mem_addr_o  = r_addr;
  assign mem_wdata_o = r_wdata;
  assign busy_o      = ~w_idle;

  // Arbitration FSM: capture the winner in IDLE, issue, then await the response.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state   <= IDLE;
      r_owner_d <= 1'b0;
      r_we      <= 1'b0;
      r_be      <= '0;
      r_addr    <= '0;
      r_wdata   <= '0;
`ifdef ARB_ROUND_ROBIN_EN
      r_last_d  <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (w_any_req) begin
            r_owner_d <= w_pick_d;
`ifdef ARB_ROUND_ROBIN_EN
            r_last_d  <= w_pick_d;
`endif
            if (w_pick_d) begin
              r_we    <= d_we_i;
              r_be    <= d_be_i;
              r_addr  <= d_addr_i;
              r_wdata <= d_wdata_i;
            end else begin
              r_we    <= 1'b0;
              r_be    <= '1;
              r_addr  <= if_addr_i;
              r_wdata <= '0;
            end
            r_state <= ISSUE;
          end
        end
        ISSUE: begin
          // A response arriving together with the grant belongs to nothing yet.
          if (mem_gnt_i) r_state <= WAIT;
        end
        WAIT: begin
          if (mem_rvalid_i) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The module SHALL have parameter ADDR_W, default 32, meaning address width in bits.
REQ-002 The module SHALL have parameter DATA_W, default 32, meaning data width in bits (the byte-enable width is DATA_W/8).
REQ-003 The module SHALL use one clock; reset is asynchronous and active-low: clk_i  in  1  rising-edge clock.
REQ-004 rst_ni  in  1  asynchronous active-low reset.
REQ-005 if_req_i  in  1  instruction fetch request, held stable until granted; if_addr_i  in  ADDR_W  fetch address.
REQ-006 if_gnt_o  out  1  fetch request accepted; if_rvalid_o  out  1  fetch data valid; if_rdata_o  out  DATA_W  fetch data.
REQ-007 d_req_i  in  1  load/store request, held stable until granted; d_we_i  in  1  1 = store; d_be_i  in  DATA_W/8  byte enables.
REQ-008 d_addr_i  in  ADDR_W  load/store address; d_wdata_i  in  DATA_W  store data.
REQ-009 d_gnt_o  out  1  load/store accepted; d_rvalid_o  out  1  load data valid or store complete; d_rdata_o  out  DATA_W  load data.
REQ-010 mem_req_o, mem_we_o  out  1 each; mem_be_o  out  DATA_W/8; mem_addr_o  out  ADDR_W; mem_wdata_o  out  DATA_W: shared memory port.
REQ-011 mem_gnt_i  in  1  memory accepts the request; mem_rvalid_i  in  1  response valid; mem_rdata_i  in  DATA_W  read data.
REQ-012 busy_o  out  1  asserted when a transaction is in flight.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, ISSUE and WAIT, and at most one memory transaction SHALL be outstanding at a time.
REQ-014 In IDLE with at least one request, the FSM SHALL select a winner, pulse the winner's gnt_o for one cycle, register its we/be/addr/wdata (we=0, be=all ones for fetch), record the owner, and go to ISSUE.
REQ-015 In IDLE with no request, all gnt_o SHALL be 0 and the FSM SHALL remain in IDLE.
REQ-016 gnt_o SHALL be combinational from the req_i inputs in IDLE, and the losing requester SHALL receive no gnt_o.
REQ-017 In ISSUE, mem_req_o SHALL be 1 and the mem_* outputs SHALL be held constant; on mem_gnt_i=1 the FSM SHALL go to WAIT.
REQ-018 In WAIT, mem_req_o SHALL be 0; on mem_rvalid_i=1 the FSM SHALL pulse the owner's rvalid_o in the same cycle and return to IDLE.
REQ-019 The owner's rdata_o SHALL equal mem_rdata_i while its rvalid_o=1; otherwise rdata_o SHALL be 0, and the non-owner's rvalid_o SHALL stay 0.
REQ-020 A store SHALL also complete via d_rvalid_o on mem_rvalid_i.
REQ-021 Minimum latency SHALL be: req accepted at cycle N, mem_req_o at N+1, rvalid_o at N+2 if mem_gnt_i at N+1 and mem_rvalid_i at N+2.
REQ-022 A new grant SHALL be possible in the cycle after rvalid_o, with no extra bubble.
REQ-023 mem_rvalid_i in IDLE or ISSUE SHALL be ignored and SHALL produce no rvalid_o.
REQ-024 busy_o SHALL be 1 in ISSUE and WAIT and 0 in IDLE.
REQ-025 mem_gnt_i and mem_rvalid_i asserted in the same ISSUE cycle SHALL be treated as a grant only, and the FSM SHALL wait in WAIT for a later rvalid.

Reset
REQ-026 On rst_ni=0 the FSM SHALL go to IDLE asynchronously, without waiting for a clock edge.
REQ-027 During reset all outputs SHALL be 0, the registered mem_* fields SHALL be 0, and the last-owner flag SHALL be set to fetch.
REQ-028 Reset mid-transaction SHALL abandon the transaction, with no rvalid_o issued for it afterward.

Configuration
REQ-029 Macro ARB_ROUND_ROBIN_EN SHALL select the arbitration policy: when defined, the requester not served last SHALL win if both request in IDLE; with a single requester, it SHALL always win.
REQ-030 Without ARB_ROUND_ROBIN_EN, the data port SHALL always win when both request, the last-owner flag SHALL not be implemented, and all other behaviour SHALL be identical.

Verification
REQ-031 Single fetch: if_req_i=1, if_addr_i=0x100, mem_gnt_i immediate, rvalid next cycle with rdata 0xDEADBEEF -> if_gnt_o at N, mem_req_o/addr 0x100 at N+1, if_rvalid_o=1 with if_rdata_o=0xDEADBEEF at N+2.
REQ-032 Store: d_we_i=1, d_be_i=4'b0011, d_addr_i=0x2000, d_wdata_i=0x12345678 -> mem_we_o=1, mem_be_o=0011 and mem_wdata_o held for 3 stall cycles of mem_gnt_i, then d_rvalid_o pulses once.
REQ-033 Contention: if_req_i and d_req_i both held over two transactions -> without macro, data then data (fetch starved while d_req_i=1); with macro, data then fetch.
REQ-034 Reset in WAIT with address 0x40, then mem_rvalid_i=1 after release -> no if_rvalid_o/d_rvalid_o, busy_o=0, all outputs 0 during reset.
REQ-035 Back-to-back fetches 0x0 and 0x4 with zero-wait memory -> second if_gnt_o in the cycle after the first if_rvalid_o, and mem_req_o for 0x4 two cycles after.
REQ-036 Spurious mem_rvalid_i=1 in IDLE -> no rvalid_o, and the state stays IDLE.
